// File: rtl/rev_gpio_ext_if.sv
// rev_gpio_ext_if: APB bus bundle between a bus master and the rev_gpio_ext slave.
interface rev_gpio_ext_if #(
    parameter int GPIO_PINS  = 32,
    parameter int PADDR_SIZE = 4
);
    logic                   psel;
    logic                   penable;
    logic                   pwrite;
    logic [PADDR_SIZE-1:0]  paddr;
    logic [GPIO_PINS-1:0]   pwrdata;
    logic [GPIO_PINS/8-1:0] pstrb;
    logic                   pready;
    logic [GPIO_PINS-1:0]   prddata;
    logic                   pslverr;
    modport master (output psel, penable, pwrite, paddr, pwrdata, pstrb, input pready, prddata, pslverr);
    modport slave (input psel, penable, pwrite, paddr, pwrdata, pstrb, output pready, prddata, pslverr);
endinterface

// File: rtl/rev_gpio_ext.sv
// rev_gpio_ext: APB GPIO with atomic SET/CLR/TGL, level/edge triggers and pslverr.
// The per-pin debounce filter is built only when REV_GPIO_DEBOUNCE_EN is defined.
module rev_gpio_ext #(
    parameter int          GPIO_PINS       = 32,
    parameter int          PADDR_SIZE      = 4,
    parameter int          SYNC_STAGES     = 2,
    parameter int          DB_CNT_W        = 4,
    parameter logic [15:0] DB_PRESCALE_RST = 16'd99
) (
    input  logic                 pclk,
    input  logic                 prst,
    rev_gpio_ext_if.slave        apb,
    input  logic [GPIO_PINS-1:0] gpio_i,
    output logic [GPIO_PINS-1:0] gpio_o,
    output logic [GPIO_PINS-1:0] gpio_oe,
    output logic                 irq_o
);
    localparam int A_MODE = 0, A_DIR = 1, A_OUT = 2, A_IN = 3, A_TYPE = 4, A_LVL0 = 5, A_LVL1 = 6;
    localparam int A_STAT = 7, A_IEN = 8, A_SET = 9, A_CLR = 10, A_TGL = 11, A_DBEN = 12, A_PRE = 13;
    if (GPIO_PINS % 8 != 0 || GPIO_PINS < 8 || GPIO_PINS > 64 || SYNC_STAGES < 2 || DB_CNT_W < 1 ||
        $bits(DB_PRESCALE_RST) != 16) begin : g_bad_cfg
        $error("rev_gpio_ext: unsupported parameter set");
    end
    logic [GPIO_PINS-1:0] mode_q, mode_d, dir_q, dir_d, out_q, out_d, type_q, type_d;
    logic [GPIO_PINS-1:0] lvl0_q, lvl0_d, lvl1_q, lvl1_d, stat_q, stat_d, ien_q, ien_d;
    logic [GPIO_PINS-1:0] in_q, in_d, in_dly_q, gpo_q, gpo_d, gpoe_q, gpoe_d, rd_q, rd_d;
    logic [GPIO_PINS-1:0] wm, wd, sync_out, db_en_rd, db_pre_rd, rise, fall;
    logic [GPIO_PINS-1:0] sync_q [SYNC_STAGES];
    logic                 irq_q, irq_d, err, wr;

    function automatic logic hit(input int a);
        return wr && int'(apb.paddr) == a;
    endfunction

    function automatic logic [GPIO_PINS-1:0] upd(input logic [GPIO_PINS-1:0] q, input int a);
        return hit(a) ? q & ~wm | wd : q;
    endfunction

    assign err      = apb.psel && apb.penable && (int'(apb.paddr) > A_PRE || apb.pwrite && int'(apb.paddr) == A_IN);
    assign wr       = apb.psel && apb.penable && apb.pwrite && !err;
    assign sync_out = sync_q[SYNC_STAGES-1];
    assign apb.pready  = 1'b1;
    assign apb.pslverr = err;
    assign apb.prddata = rd_q;
    assign gpio_o  = gpo_q;
    assign gpio_oe = gpoe_q;
    assign irq_o   = irq_q;

    always_comb begin
        wm = '0;
        for (int b = 0; b < GPIO_PINS / 8; b++) wm[8*b +: 8] = {8{apb.pstrb[b]}};
        wd = apb.pwrdata & wm;
    end

    always_comb begin
        mode_d = upd(mode_q, A_MODE);
        dir_d  = upd(dir_q, A_DIR);
        type_d = upd(type_q, A_TYPE);
        lvl0_d = upd(lvl0_q, A_LVL0);
        lvl1_d = upd(lvl1_q, A_LVL1);
        ien_d  = upd(ien_q, A_IEN);
        out_d  = hit(A_OUT) ? out_q & ~wm | wd :
                 hit(A_SET) ? out_q | wd :
                 hit(A_CLR) ? out_q & ~wd :
                 hit(A_TGL) ? out_q ^ wd : out_q;
        rise   = in_q & ~in_dly_q;
        fall   = ~in_q & in_dly_q;
        // Clear first, then OR in the trigger so a coincident set survives the W1C.
        stat_d = stat_q & ~(hit(A_STAT) ? wd : '0) |
                 type_q & (lvl0_q & fall | lvl1_q & rise) |
                 ~type_q & (lvl0_q & ~in_q | lvl1_q & in_q);
        gpo_d  = ~mode_q & out_q;
        gpoe_d = dir_q & ~(mode_q & out_q);
        irq_d  = |(stat_q & ien_q);
        case (int'(apb.paddr))
            A_MODE:  rd_d = mode_q;
            A_DIR:   rd_d = dir_q;
            A_OUT:   rd_d = out_q;
            A_IN:    rd_d = in_q;
            A_TYPE:  rd_d = type_q;
            A_LVL0:  rd_d = lvl0_q;
            A_LVL1:  rd_d = lvl1_q;
            A_STAT:  rd_d = stat_q;
            A_IEN:   rd_d = ien_q;
            A_DBEN:  rd_d = db_en_rd;
            A_PRE:   rd_d = db_pre_rd;
            default: rd_d = '0;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (prst) begin
            mode_q   <= '0;
            dir_q    <= '0;
            out_q    <= '0;
            type_q   <= '0;
            lvl0_q   <= '0;
            lvl1_q   <= '0;
            stat_q   <= '0;
            ien_q    <= '0;
            in_q     <= '0;
            in_dly_q <= '0;
            gpo_q    <= '0;
            gpoe_q   <= '0;
            rd_q     <= '0;
            irq_q    <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            mode_q   <= mode_d;
            dir_q    <= dir_d;
            out_q    <= out_d;
            type_q   <= type_d;
            lvl0_q   <= lvl0_d;
            lvl1_q   <= lvl1_d;
            stat_q   <= stat_d;
            ien_q    <= ien_d;
            in_q     <= in_d;
            in_dly_q <= in_q;
            gpo_q    <= gpo_d;
            gpoe_q   <= gpoe_d;
            rd_q     <= rd_d;
            irq_q    <= irq_d;
            sync_q[0] <= gpio_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

`ifdef REV_GPIO_DEBOUNCE_EN
    localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'((1 << DB_CNT_W) - 2);
    logic [GPIO_PINS-1:0] dben_q, dben_d;
    logic [15:0]          pre_q, pre_d, pcnt_q, pcnt_d;
    logic [DB_CNT_W-1:0]  dbc_q [GPIO_PINS];
    logic [DB_CNT_W-1:0]  dbc_d [GPIO_PINS];
    logic                 tick;

    always_comb begin
        dben_d = upd(dben_q, A_DBEN);
        pre_d  = hit(A_PRE) ? pre_q & ~16'(wm) | 16'(wd) : pre_q;
        tick   = pcnt_q == pre_q;
        pcnt_d = hit(A_PRE) || tick ? 16'd0 : pcnt_q + 16'd1;
        in_d   = sync_out;
        // The flip happens on the tick that would take the counter to its all-ones value.
        for (int n = 0; n < GPIO_PINS; n++) begin
            dbc_d[n] = '0;
            if (dben_q[n]) begin
                in_d[n]  = in_q[n] ^ (tick && sync_out[n] != in_q[n] && dbc_q[n] == DB_LAST);
                dbc_d[n] = !tick ? dbc_q[n] :
                           (sync_out[n] == in_q[n] || dbc_q[n] == DB_LAST) ? '0 : dbc_q[n] + 1'b1;
            end
        end
        db_en_rd  = dben_q;
        db_pre_rd = GPIO_PINS'(pre_q);
    end

    always_ff @(posedge pclk) begin
        if (prst) begin
            dben_q <= '0;
            pre_q  <= DB_PRESCALE_RST;
            pcnt_q <= '0;
            for (int n = 0; n < GPIO_PINS; n++) dbc_q[n] <= '0;
        end else begin
            dben_q <= dben_d;
            pre_q  <= pre_d;
            pcnt_q <= pcnt_d;
            for (int n = 0; n < GPIO_PINS; n++) dbc_q[n] <= dbc_d[n];
        end
    end
`else
    always_comb begin
        in_d      = sync_out;
        db_en_rd  = '0;
        db_pre_rd = '0;
    end
`endif
endmodule

// File: tb/tb_rev_gpio_ext.sv
// tb_rev_gpio_ext: vector table, hand-written trigger/reset sequences and a randomized
// register/pad run compared against a register-level reference model.
module tb_rev_gpio_ext;
    localparam int W = 32;
`ifdef REV_GPIO_DEBOUNCE_EN
    localparam int          DBW     = 2;
    localparam logic [31:0] PRE_RST = 32'd99;
`else
    localparam int          DBW     = 4;
    localparam logic [31:0] PRE_RST = 32'd0;
`endif
    typedef struct {
        logic        wr;
        logic [3:0]  a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    logic pclk = 1'b0, prst = 1'b1, irq_o;
    logic [W-1:0] gpio_i = '0, gpio_o, gpio_oe;
    int checks = 0, errors = 0, cyc = 0;
    logic [W-1:0] m_mode, m_dir, m_out, m_ien;

    rev_gpio_ext_if #(.GPIO_PINS(W), .PADDR_SIZE(4)) bus ();
    rev_gpio_ext #(.GPIO_PINS(W), .PADDR_SIZE(4), .SYNC_STAGES(2), .DB_CNT_W(DBW), .DB_PRESCALE_RST(16'd99)) dut (
        .pclk(pclk), .prst(prst), .apb(bus), .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe), .irq_o(irq_o)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apb(input logic w, input logic [3:0] a, input logic [W-1:0] d, input logic [3:0] s,
                       output logic [W-1:0] rd, output logic err);
        @(negedge pclk);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = w; bus.paddr = a; bus.pwrdata = d; bus.pstrb = s;
        @(negedge pclk);
        bus.penable = 1'b1;
        #1 rd = bus.prddata; err = bus.pslverr;
        @(negedge pclk);
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    endtask

    function automatic logic [W-1:0] bmask(input logic [3:0] s);
        logic [W-1:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{s[b]}};
        return m;
    endfunction

    task automatic model_wr(input logic [3:0] a, input logic [W-1:0] d, input logic [3:0] s);
        logic [W-1:0] m;
        m = bmask(s);
        case (a)
            4'd0:  m_mode = m_mode & ~m | d & m;
            4'd1:  m_dir  = m_dir & ~m | d & m;
            4'd2:  m_out  = m_out & ~m | d & m;
            4'd8:  m_ien  = m_ien & ~m | d & m;
            4'd9:  m_out  = m_out | d & m;
            4'd10: m_out  = m_out & ~(d & m);
            4'd11: m_out  = m_out ^ (d & m);
            default: ;
        endcase
    endtask

    function automatic logic [W-1:0] model_rd(input logic [3:0] a);
        case (a)
            4'd0: return m_mode;
            4'd1: return m_dir;
            4'd2: return m_out;
            4'd3: return gpio_i;
            4'd8: return m_ien;
            default: return '0;
        endcase
    endfunction

    initial begin
        vec_t tbl[20];
        logic [3:0] addrs[10];
        logic [W-1:0] rd;
        logic e;
        int t0;
        tbl[0]  = '{1'b0, 4'd0,  32'h0,        4'hF, 32'h0,        1'b0};
        tbl[1]  = '{1'b1, 4'd2,  32'h0000_00F0, 4'hF, 32'h0,        1'b0};
        tbl[2]  = '{1'b1, 4'd1,  32'h0000_00FF, 4'hF, 32'h0,        1'b0};
        tbl[3]  = '{1'b1, 4'd9,  32'h0000_0001, 4'hF, 32'h0,        1'b0};
        tbl[4]  = '{1'b1, 4'd10, 32'h0000_0010, 4'hF, 32'h0,        1'b0};
        tbl[5]  = '{1'b1, 4'd11, 32'h0000_0003, 4'hF, 32'h0,        1'b0};
        tbl[6]  = '{1'b0, 4'd2,  32'h0,        4'hF, 32'h0000_00E2, 1'b0};
        tbl[7]  = '{1'b0, 4'd11, 32'h0,        4'hF, 32'h0,        1'b0};
        tbl[8]  = '{1'b1, 4'd0,  32'hFFFF_FFFF, 4'b0101, 32'h0,     1'b0};
        tbl[9]  = '{1'b0, 4'd0,  32'h0,        4'hF, 32'h00FF_00FF, 1'b0};
        tbl[10] = '{1'b1, 4'd0,  32'h0,        4'hF, 32'h0,        1'b0};
        tbl[11] = '{1'b0, 4'd14, 32'h0,        4'hF, 32'h0,        1'b1};
        tbl[12] = '{1'b1, 4'd3,  32'hFFFF_FFFF, 4'hF, 32'h0,        1'b1};
        tbl[13] = '{1'b0, 4'd3,  32'h0,        4'hF, 32'h0,        1'b0};
        tbl[14] = '{1'b0, 4'd12, 32'h0,        4'hF, 32'h0,        1'b0};
        tbl[15] = '{1'b0, 4'd13, 32'h0,        4'hF, PRE_RST,      1'b0};
        tbl[16] = '{1'b1, 4'd15, 32'h1234_5678, 4'hF, 32'h0,        1'b1};
        tbl[17] = '{1'b1, 4'd9,  32'hFFFF_0000, 4'b0100, 32'h0,     1'b0};
        tbl[18] = '{1'b0, 4'd2,  32'h0,        4'hF, 32'h00FF_00E2, 1'b0};
        tbl[19] = '{1'b1, 4'd10, 32'hFFFF_FFFF, 4'b0100, 32'h0,     1'b0};
        addrs = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd8, 4'd9, 4'd10, 4'd11, 4'd14, 4'd15};
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = '0; bus.pwrdata = '0; bus.pstrb = '0;

        repeat (3) @(negedge pclk);
        check("rst_gpio_o", gpio_o, '0);
        check("rst_gpio_oe", gpio_oe, '0);
        check("rst_irq", W'(irq_o), '0);
        check("rst_prddata", bus.prddata, '0);
        check("pready", W'(bus.pready), W'(1));
        prst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            apb(tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].s, rd, e);
            check($sformatf("vec%0d_err", i), W'(e), W'(tbl[i].exp_err));
            if (!tbl[i].wr) check($sformatf("vec%0d_rd", i), rd, tbl[i].exp_rd);
        end
        apb(1'b0, 4'd2, '0, 4'hF, rd, e);
        check("out_after_strobed_clr", rd, 32'h0000_00E2);
        check("pad_o_atomic", gpio_o, 32'h0000_00E2);
        check("pad_oe_atomic", gpio_oe, 32'h0000_00FF);
        apb(1'b1, 4'd11, 32'h1, 4'hF, rd, e);
        check("pad_o_not_yet", gpio_o, 32'h0000_00E2);
        @(negedge pclk);
        check("pad_o_one_cycle", gpio_o, 32'h0000_00E3);
        apb(1'b1, 4'd11, 32'h1, 4'hF, rd, e);

        // Both-edge trigger on pin 3.
        apb(1'b1, 4'd4, 32'h8, 4'hF, rd, e);
        apb(1'b1, 4'd5, 32'h8, 4'hF, rd, e);
        apb(1'b1, 4'd6, 32'h8, 4'hF, rd, e);
        apb(1'b1, 4'd8, 32'h8, 4'hF, rd, e);
        check("irq_idle", W'(irq_o), '0);
        gpio_i[3] = 1'b1;
        repeat (4) @(negedge pclk);
        check("rise_irq_before", W'(irq_o), '0);
        @(negedge pclk);
        check("rise_irq", W'(irq_o), W'(1));
        apb(1'b0, 4'd7, '0, 4'hF, rd, e);
        check("rise_stat", rd, 32'h8);
        apb(1'b1, 4'd7, 32'h8, 4'hF, rd, e);
        check("w1c_irq_hold", W'(irq_o), W'(1));
        @(negedge pclk);
        check("w1c_irq_drop", W'(irq_o), '0);
        apb(1'b0, 4'd7, '0, 4'hF, rd, e);
        check("w1c_stat", rd, '0);
        gpio_i[3] = 1'b0;
        repeat (4) @(negedge pclk);
        check("fall_irq_before", W'(irq_o), '0);
        @(negedge pclk);
        check("fall_irq", W'(irq_o), W'(1));
        apb(1'b0, 4'd7, '0, 4'hF, rd, e);
        check("fall_stat", rd, 32'h8);
        apb(1'b1, 4'd5, 32'h0, 4'hF, rd, e);
        apb(1'b1, 4'd6, 32'h0, 4'hF, rd, e);
        apb(1'b1, 4'd7, 32'h8, 4'hF, rd, e);

        // Level-high trigger on pin 0 keeps the status bit alive through a W1C.
        gpio_i[0] = 1'b1;
        repeat (4) @(negedge pclk);
        apb(1'b1, 4'd6, 32'h1, 4'hF, rd, e);
        apb(1'b1, 4'd8, 32'h9, 4'hF, rd, e);
        repeat (2) @(negedge pclk);
        check("lvl_irq", W'(irq_o), W'(1));
        apb(1'b1, 4'd7, 32'h1, 4'hF, rd, e);
        check("setwins_irq0", W'(irq_o), W'(1));
        @(negedge pclk);
        check("setwins_irq1", W'(irq_o), W'(1));
        apb(1'b0, 4'd7, '0, 4'hF, rd, e);
        check("setwins_stat", rd, 32'h1);

        // Reset asserted in the access phase of an OUT write.
        @(negedge pclk);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1; bus.paddr = 4'd2; bus.pwrdata = '1; bus.pstrb = 4'hF;
        @(negedge pclk);
        bus.penable = 1'b1; prst = 1'b1;
        @(negedge pclk);
        check("rstw_gpio_o", gpio_o, '0);
        check("rstw_gpio_oe", gpio_oe, '0);
        check("rstw_irq", W'(irq_o), '0);
        check("rstw_prddata", bus.prddata, '0);
        prst = 1'b0; bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        apb(1'b0, 4'd2, '0, 4'hF, rd, e);
        check("rstw_out_lost", rd, '0);
        m_mode = '0; m_dir = '0; m_out = '0; m_ien = '0;

        gpio_i = $urandom;
        repeat (4) @(negedge pclk);
        for (int i = 0; i < 150; i++) begin
            logic [3:0] a, s;
            logic [W-1:0] d;
            logic w;
            if ($urandom_range(0, 5) == 0) begin
                gpio_i = $urandom;
                repeat (4) @(negedge pclk);
            end
            a = addrs[$urandom_range(0, 9)];
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            s = 4'($urandom);
            apb(w, a, d, s, rd, e);
            check("rnd_err", W'(e), W'(a > 4'd13 || (w && a == 4'd3)));
            if (!w) check($sformatf("rnd_rd_a%0d", a), rd, model_rd(a));
            else begin
                model_wr(a, d, s);
                @(negedge pclk);
                check("rnd_gpio_o", gpio_o, m_out & ~m_mode);
                check("rnd_gpio_oe", gpio_oe, m_dir & ~(m_mode & m_out));
                check("rnd_irq", W'(irq_o), '0);
            end
        end

`ifdef REV_GPIO_DEBOUNCE_EN
        gpio_i = '0;
        repeat (4) @(negedge pclk);
        apb(1'b1, 4'd13, 32'h3, 4'hF, rd, e);
        apb(1'b1, 4'd12, 32'h1, 4'hF, rd, e);
        apb(1'b0, 4'd13, '0, 4'hF, rd, e);
        check("db_prescale", rd, 32'h3);
        gpio_i[0] = 1'b1;
        repeat (5) @(negedge pclk);
        gpio_i[0] = 1'b0;
        repeat (30) @(negedge pclk);
        apb(1'b0, 4'd3, '0, 4'hF, rd, e);
        check("db_glitch", W'(rd[0]), '0);
        t0 = cyc;
        gpio_i[0] = 1'b1;
        rd = '0;
        for (int k = 0; k < 15 && !rd[0]; k++) apb(1'b0, 4'd3, '0, 4'hF, rd, e);
        check("db_steady_seen", W'(rd[0]), W'(1));
        check("db_steady_latency_ok", W'(cyc - t0 >= 10 && cyc - t0 <= 20), W'(1));
`else
        t0 = 0;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks + t0 * 0);
        $finish;
    end
endmodule
